gfx_frame_writer: RTL and testbench
===================================

Name: gfx_frame_writer

Overview:
- Host-side shadow register file plus bus sequencer that feeds the graphics ASIC's register interface (chipselect/read/databus/data_address).
- The game logic writes ball/paddle/score values into the shadow file at any time.
- Once per frame, on the start of vertical sync, the block streams every changed entry to the graphics ASIC, so register updates never tear mid-frame.
- Sits directly upstream of the graphics ASIC in top.

Parameters:
- NUM_REGS, 16, number of shadow entries; equals graphics ASIC register count.
- ADDR_W, 4, address width; log2(NUM_REGS).
- DATA_W, 16, register/data bus width.

Ports:
- clk  input  1  system clock, the 100 MHz buffered clock.
- rst  input  1  asynchronous, active-low reset.
- host_we  input  1  host write strobe; one entry per cycle.
- host_addr  input  ADDR_W  host write/read address.
- host_wdata  input  DATA_W  host write data.
- host_rdata  output  DATA_W  shadow[host_addr], registered; valid 1 cycle after address.
- force_all  input  1  1-cycle pulse; marks every entry dirty.
- vsync  input  1  VGA vsync from vga_controller, active low, same clock domain.
- chipselect  output  1  bus select to graphics ASIC.
- read  output  1  bus direction; always 0 (write-only master).
- databus  output  DATA_W  write data to graphics ASIC; tri-state conversion is done in top.
- data_address  output  ADDR_W  graphics ASIC register address.
- busy  output  1  high while a flush is in progress.
- flush_done  output  1  1-cycle pulse at end of each flush.

Behaviour:
Reset (rst=0, async):
- shadow[] = 0; dirty[] = 0; state IDLE; idx = 0.
- chipselect=0, read=0, databus=0, data_address=0, busy=0, flush_done=0, host_rdata=0.
- vsync_q = 1.

Host writes:
- host_we=1 writes shadow[host_addr] and sets dirty[host_addr] at the clock edge.
- Accepted in any state.

Flush trigger:
- vsync_q registers vsync.
- A falling edge (vsync_q=1, vsync=0) while in IDLE starts a flush.
- Edges seen while busy are ignored; no queueing.

force_all:
- Sets all dirty bits.
- If coincident with a clear in WRITE, the set wins.

FSM (all outputs registered):
- IDLE: busy=0. On trigger: idx=0, go to SCAN.
- SCAN (busy=1):
  - If dirty[idx]: latch shadow[idx] into the data register, go to WRITE.
  - Else if idx==NUM_REGS-1: go to IDLE, pulse flush_done.
  - Else idx++, stay in SCAN.
- WRITE: chipselect=1, read=0, data_address=idx, databus=latched data, all for exactly 1 cycle.
  - dirty[idx] clears, unless host_we to the same idx or force_all happens this cycle; then it stays set and is sent next frame.
  - Go to GAP.
- GAP: chipselect=0 (one mandatory idle bus cycle between writes).
  - If idx==NUM_REGS-1: go to IDLE, pulse flush_done.
  - Else idx++, go to SCAN.

Bus and timing rules:
- databus and data_address hold their last values when chipselect=0.
- Flush length = NUM_REGS scan cycles + 2 per dirty entry. Range is 16 to 48 cycles.
- Flush always ends well inside vertical blank.
- Data sent is the value latched in SCAN. A host write landing during WRITE/GAP re-dirties the entry; it is not merged into the current transfer.
- Entries are sent in ascending address order.

Mid-operation reset:
- rst asserted during a flush aborts immediately to reset values.
- Dirty state is lost.
- chipselect drops asynchronously.

Test Plan:
1. Reset, then no host writes, then vsync falling edge:
   - busy is high for 16 cycles.
   - flush_done pulses.
   - chipselect is never asserted.
2. Write addr3=0x1234 and addr9=0xBEEF, then vsync edge:
   - Exactly two 1-cycle chipselect pulses, (3,0x1234) then (9,0xBEEF), read=0.
   - flush_done fires 20 cycles after the edge.
   - A second vsync edge produces no writes.
3. force_all pulse, then vsync edge:
   - 16 writes, addresses 0..15 with shadow values, each separated by one idle cycle.
   - busy high for 48 cycles.
4. Write addr5=0x0001, start flush, host writes addr5=0x0002 in the WRITE cycle for addr5:
   - Bus carries 0x0001.
   - dirty[5] remains set.
   - Next frame sends 0x0002.
5. vsync edge during an active flush:
   - Ignored; a single flush_done.
   - After IDLE, the next edge starts a fresh flush.
6. Assert rst low mid-flush while chipselect=1:
   - chipselect drops without a clock edge.
   - All outputs return to 0.
   - After release, a vsync edge produces no writes.
   - host_rdata(addr3) = 0x0000, one cycle after addr3 is presented.

Source files
------------

// File: rtl/gfx_frame_writer_if.sv
// Host-side shadow-register and graphics-ASIC bus signals of the frame writer.
// master = the frame writer itself; slave = host logic plus the graphics ASIC.
interface gfx_frame_writer_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 16
);
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;
    logic              force_all;
    logic              vsync;
    logic              chipselect;
    logic              read;
    logic [DATA_W-1:0] databus;
    logic [ADDR_W-1:0] data_address;
    logic              busy;
    logic              flush_done;

    modport master (
        input  host_we, host_addr, host_wdata, force_all, vsync,
        output host_rdata, chipselect, read, databus, data_address, busy, flush_done
    );

    modport slave (
        output host_we, host_addr, host_wdata, force_all, vsync,
        input  host_rdata, chipselect, read, databus, data_address, busy, flush_done
    );
endinterface

// File: rtl/gfx_frame_writer.sv
// Shadow register file that streams dirty entries to the graphics ASIC once per frame,
// starting on the falling edge of vsync, so register updates never tear mid-frame.
module gfx_frame_writer #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    gfx_frame_writer_if.master io_bus
);
    typedef enum logic [1:0] {StIdle, StScan, StWrite, StGap} state_e;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

    state_e              r_state, w_state_d;
    logic [ADDR_W-1:0]   r_idx, w_idx_d;
    logic [DATA_W-1:0]   r_shadow [NUM_REGS];
    logic [NUM_REGS-1:0] r_dirty, w_dirty_d;
    logic                r_vsync_q;
    logic                w_trigger, w_latch, w_clear, w_done_d;
    logic                r_cs, r_busy, r_done;
    logic [DATA_W-1:0]   r_databus, r_rdata;
    logic [ADDR_W-1:0]   r_addr;

    assign w_trigger = r_vsync_q & ~io_bus.vsync;

    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_latch   = 1'b0;
        w_clear   = 1'b0;
        w_done_d  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_trigger) begin
                    w_state_d = StScan;
                    w_idx_d   = '0;
                end
            end
            StScan: begin
                if (r_dirty[r_idx]) begin
                    w_state_d = StWrite;
                    w_latch   = 1'b1;
                end else if (r_idx == LastIdx) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end else begin
                    w_idx_d = r_idx + 1'b1;
                end
            end
            StWrite: begin
                w_clear   = 1'b1;
                w_state_d = StGap;
            end
            StGap: begin
                if (r_idx == LastIdx) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end else begin
                    w_idx_d   = r_idx + 1'b1;
                    w_state_d = StScan;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Later assignments win: a host write or force_all re-dirties an entry being cleared.
    always_comb begin
        w_dirty_d = r_dirty;
        if (w_clear) begin
            w_dirty_d[r_idx] = 1'b0;
        end
        if (io_bus.host_we) begin
            w_dirty_d[io_bus.host_addr] = 1'b1;
        end
        if (io_bus.force_all) begin
            w_dirty_d = '1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_idx     <= '0;
            r_dirty   <= '0;
            r_vsync_q <= 1'b1;
            r_cs      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_databus <= '0;
            r_addr    <= '0;
            r_rdata   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_state   <= w_state_d;
            r_idx     <= w_idx_d;
            r_dirty   <= w_dirty_d;
            r_vsync_q <= io_bus.vsync;
            r_cs      <= (w_state_d == StWrite);
            r_busy    <= (w_state_d != StIdle);
            r_done    <= w_done_d;
            r_rdata   <= r_shadow[io_bus.host_addr];
            if (io_bus.host_we) begin
                r_shadow[io_bus.host_addr] <= io_bus.host_wdata;
            end
            // Bus data/address only move when a transfer is set up; they hold otherwise.
            if (w_latch) begin
                r_databus <= r_shadow[r_idx];
                r_addr    <= r_idx;
            end
        end
    end

    assign io_bus.chipselect   = r_cs;
    assign io_bus.read         = 1'b0;
    assign io_bus.databus      = r_databus;
    assign io_bus.data_address = r_addr;
    assign io_bus.busy         = r_busy;
    assign io_bus.flush_done   = r_done;
    assign io_bus.host_rdata   = r_rdata;
endmodule

// File: tb/tb_gfx_frame_writer.sv
// Scoreboard bench for gfx_frame_writer: expected bus writes are queued as stimulus is
// applied and popped by a bus monitor whenever chipselect is seen.
module tb_gfx_frame_writer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    gfx_frame_writer_if #(.ADDR_W(4), .DATA_W(16)) bus ();

    gfx_frame_writer #(
        .NUM_REGS(16),
        .ADDR_W  (4),
        .DATA_W  (16)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [19:0] sb [$];
    logic [15:0] model [16];
    logic        prev_cs = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: every chipselect must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.chipselect === 1'b1) begin
            logic [19:0] e;
            check("cs_gap", {31'd0, prev_cs}, 32'd0);
            check("read_low", {31'd0, bus.read}, 32'd0);
            check("write_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", {28'd0, bus.data_address}, {28'd0, e[19:16]});
                check("wr_data", {16'd0, bus.databus}, {16'd0, e[15:0]});
            end
        end
        prev_cs = bus.chipselect;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [15:0] d);
        bus.host_we    = 1'b1;
        bus.host_addr  = a;
        bus.host_wdata = d;
        step();
        bus.host_we = 1'b0;
        model[a]    = d;
    endtask

    // Fires one vsync falling edge and follows the flush to its end.
    task automatic run_flush(input int exp_busy, input int inj_addr, input logic [15:0] inj_data,
                             input int dup_at);
        int cnt;
        int dones;
        bit injected;
        cnt      = 0;
        dones    = 0;
        injected = 1'b0;
        bus.vsync = 1'b0;
        step();
        bus.vsync = 1'b1;
        while (bus.busy === 1'b1 && cnt < 100) begin
            if (bus.flush_done === 1'b1) dones++;
            bus.vsync = (cnt == dup_at) ? 1'b0 : 1'b1;
            if (!injected && inj_addr >= 0 && bus.chipselect === 1'b1 &&
                bus.data_address == 4'(inj_addr)) begin
                bus.host_we    = 1'b1;
                bus.host_addr  = 4'(inj_addr);
                bus.host_wdata = inj_data;
                model[inj_addr] = inj_data;
                injected = 1'b1;
            end
            step();
            bus.host_we = 1'b0;
            bus.vsync   = 1'b1;
            cnt++;
        end
        check("busy_len", cnt, exp_busy);
        check("done_at_end", {31'd0, bus.flush_done}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (bus.flush_done === 1'b1) dones++;
            step();
        end
        check("done_count", dones, 1);
        check("idle_after", {31'd0, bus.busy}, 32'd0);
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cs"}, {31'd0, bus.chipselect}, 32'd0);
        check({tag, "_read"}, {31'd0, bus.read}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_done"}, {31'd0, bus.flush_done}, 32'd0);
        check({tag, "_dbus"}, {16'd0, bus.databus}, 32'd0);
        check({tag, "_daddr"}, {28'd0, bus.data_address}, 32'd0);
        check({tag, "_rdata"}, {16'd0, bus.host_rdata}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        bus.host_we    = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
        bus.force_all  = 1'b0;
        bus.vsync      = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = '0;
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("reset");
        step();
        step();
        rst_n = 1'b1;
        step();

        // 1: nothing dirty -> 16 scan cycles, no bus writes
        run_flush(16, -1, 16'h0, -1);

        // 2: two writes sent in ascending order; second frame is clean
        host_write(4'd9, 16'hBEEF);
        host_write(4'd3, 16'h1234);
        sb.push_back({4'd3, 16'h1234});
        sb.push_back({4'd9, 16'hBEEF});
        run_flush(20, -1, 16'h0, -1);
        run_flush(16, -1, 16'h0, -1);
        bus.host_addr = 4'd9;
        step();
        check("rdata_9", {16'd0, bus.host_rdata}, 32'h0000BEEF);

        // 3: force_all sends every entry
        bus.force_all = 1'b1;
        step();
        bus.force_all = 1'b0;
        for (int i = 0; i < 16; i++) sb.push_back({4'(i), model[i]});
        run_flush(48, -1, 16'h0, -1);

        // 4: host write during WRITE of addr5 is deferred to the next frame
        host_write(4'd5, 16'h0001);
        sb.push_back({4'd5, 16'h0001});
        run_flush(18, 5, 16'h0002, -1);
        sb.push_back({4'd5, 16'h0002});
        run_flush(18, -1, 16'h0, -1);
        run_flush(16, -1, 16'h0, -1);

        // 5: vsync edge while busy is ignored; next edge starts a fresh flush
        run_flush(16, -1, 16'h0, 5);
        host_write(4'd15, 16'hA5A5);
        sb.push_back({4'd15, 16'hA5A5});
        run_flush(18, -1, 16'h0, -1);

        // 6: reset while chipselect is high
        host_write(4'd3, 16'h5555);
        host_write(4'd7, 16'h7777);
        bus.vsync = 1'b0;
        step();
        bus.vsync = 1'b1;
        cnt = 0;
        while (bus.chipselect !== 1'b1 && cnt < 50) begin
            step();
            cnt++;
        end
        check("cs_before_rst", {31'd0, bus.chipselect}, 32'd1);
        check("cs_addr_before_rst", {28'd0, bus.data_address}, 32'd3);
        #1 rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        for (int i = 0; i < 16; i++) model[i] = '0;
        step();
        rst_n = 1'b1;
        step();
        run_flush(16, -1, 16'h0, -1);
        bus.host_addr = 4'd3;
        step();
        check("rdata_3_after_rst", {16'd0, bus.host_rdata}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
